// File: rtl/l1_mem_arbiter.sv
// rtl/l1_mem_arbiter.sv - N-port L1-to-L2 line arbiter with fixed-priority or round-robin grant
module l1_mem_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128,
    parameter int RR_MODE    = 0,
    localparam int GW        = $clog2(NUM_PORTS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PORTS-1:0]             req_read,
    input  logic [NUM_PORTS-1:0]             req_write,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_address,
    input  logic [NUM_PORTS*LINE_WIDTH-1:0]  req_wdata,
    output logic [NUM_PORTS-1:0]             req_resp,
    output logic [LINE_WIDTH-1:0]            req_rdata,
    output logic                             pmem_read,
    output logic                             pmem_write,
    output logic [ADDR_WIDTH-1:0]            pmem_address,
    output logic [LINE_WIDTH-1:0]            pmem_wdata,
    input  logic                             pmem_resp,
    input  logic [LINE_WIDTH-1:0]            pmem_rdata,
    output logic                             busy,
    output logic [GW-1:0]                    grant_id
);

    localparam logic [GW:0] NP = (GW+1)'(NUM_PORTS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SERVE,
        S_RELEASE
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [GW-1:0]          rr_ptr;
    logic [GW-1:0]          rr_next;
    logic [GW-1:0]          winner;
    logic [GW-1:0]          search_start;
    logic [GW:0]            grant_inc;
    logic [NUM_PORTS-1:0]   pending;
    logic                   sel_read;
    logic                   sel_write;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [LINE_WIDTH-1:0]  sel_wdata;

    // First pending port found scanning upward from start, wrapping at NUM_PORTS.
    function automatic logic [GW-1:0] pick_winner(input logic [NUM_PORTS-1:0] pend,
                                                   input logic [GW-1:0]        start);
        logic [GW-1:0] win;
        logic          found;
        logic [GW:0]   idx;
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = {1'b0, start} + (GW+1)'(k);
            if (idx >= NP) begin
                idx = idx - NP;
            end
            if (!found && pend[idx[GW-1:0]]) begin
                win   = idx[GW-1:0];
                found = 1'b1;
            end
        end
        return win;
    endfunction

    assign pending      = req_read | req_write;
    assign search_start = (RR_MODE != 0) ? rr_ptr : {GW{1'b0}};
    assign winner       = pick_winner(pending, search_start);
    assign grant_inc    = {1'b0, grant_id} + {{GW{1'b0}}, 1'b1};
    assign rr_next      = (grant_inc >= NP) ? {GW{1'b0}} : grant_inc[GW-1:0];

    always_comb begin
        sel_read  = 1'b0;
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_id == GW'(i)) begin
                sel_read  = req_read[i];
                sel_write = req_write[i];
                sel_addr  = req_address[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata[i*LINE_WIDTH +: LINE_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            grant_id <= '0;
            rr_ptr   <= '0;
        end else begin
            state <= state_next;
            if (state == S_IDLE && |pending) begin
                grant_id <= winner;
            end
            if (state == S_RELEASE) begin
                rr_ptr <= rr_next;
            end
        end
    end

    // A completion beats an abort: if L2 answers in the cycle the port drops, it still gets req_resp.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (|pending) begin
                    state_next = S_SERVE;
                end
            end
            S_SERVE: begin
                if (pmem_resp) begin
                    state_next = S_RELEASE;
                end else if (!(sel_read || sel_write)) begin
                    state_next = S_IDLE;
                end
            end
            S_RELEASE: state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        req_resp     = '0;
        req_rdata    = pmem_rdata;
        busy         = (state != S_IDLE);
        if (state == S_SERVE) begin
            pmem_write   = sel_write;
            pmem_read    = sel_read & ~sel_write;
            pmem_address = sel_addr;
            pmem_wdata   = sel_wdata;
            for (int i = 0; i < NUM_PORTS; i++) begin
                req_resp[i] = pmem_resp && (grant_id == GW'(i));
            end
        end
    end

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// tb/tb_l1_mem_arbiter.sv - scoreboard bench: fixed-priority 2-port and round-robin 3-port instances
module tb_l1_mem_arbiter;

    typedef struct {
        int           cyc;
        int           gid;
        logic         rd;
        logic         wr;
        logic [15:0]  addr;
        logic [127:0] wdata;
    } srv_t;

    typedef struct {
        int           cyc;
        logic [2:0]   resp;
        logic [127:0] rdata;
    } rsp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // fixed-priority, 2 ports
    logic         rst_fp;
    logic [1:0]   req_read_fp, req_write_fp, req_resp_fp;
    logic [31:0]  req_address_fp;
    logic [255:0] req_wdata_fp;
    logic [127:0] req_rdata_fp, pmem_wdata_fp, pmem_rdata_fp;
    logic         pmem_read_fp, pmem_write_fp, pmem_resp_fp, busy_fp;
    logic [15:0]  pmem_address_fp;
    logic [0:0]   grant_id_fp;

    // round-robin, 3 ports
    logic         rst_rr;
    logic [2:0]   req_read_rr, req_write_rr, req_resp_rr;
    logic [47:0]  req_address_rr;
    logic [383:0] req_wdata_rr;
    logic [127:0] req_rdata_rr, pmem_wdata_rr, pmem_rdata_rr;
    logic         pmem_read_rr, pmem_write_rr, pmem_resp_rr, busy_rr;
    logic [15:0]  pmem_address_rr;
    logic [1:0]   grant_id_rr;

    l1_mem_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(16), .LINE_WIDTH(128), .RR_MODE(0)) u_fp (
        .clk(clk), .rst(rst_fp),
        .req_read(req_read_fp), .req_write(req_write_fp),
        .req_address(req_address_fp), .req_wdata(req_wdata_fp),
        .req_resp(req_resp_fp), .req_rdata(req_rdata_fp),
        .pmem_read(pmem_read_fp), .pmem_write(pmem_write_fp),
        .pmem_address(pmem_address_fp), .pmem_wdata(pmem_wdata_fp),
        .pmem_resp(pmem_resp_fp), .pmem_rdata(pmem_rdata_fp),
        .busy(busy_fp), .grant_id(grant_id_fp)
    );

    l1_mem_arbiter #(.NUM_PORTS(3), .ADDR_WIDTH(16), .LINE_WIDTH(128), .RR_MODE(1)) u_rr (
        .clk(clk), .rst(rst_rr),
        .req_read(req_read_rr), .req_write(req_write_rr),
        .req_address(req_address_rr), .req_wdata(req_wdata_rr),
        .req_resp(req_resp_rr), .req_rdata(req_rdata_rr),
        .pmem_read(pmem_read_rr), .pmem_write(pmem_write_rr),
        .pmem_address(pmem_address_rr), .pmem_wdata(pmem_wdata_rr),
        .pmem_resp(pmem_resp_rr), .pmem_rdata(pmem_rdata_rr),
        .busy(busy_rr), .grant_id(grant_id_rr)
    );

    srv_t q_srv_fp[$];
    rsp_t q_rsp_fp[$];
    srv_t q_srv_rr[$];
    rsp_t q_rsp_rr[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // monitors: a transaction start is the first cycle pmem_read/write rises
    srv_t s_fp, s_rr;
    rsp_t r_fp, r_rr;
    logic act_fp, prev_fp = 1'b0, act_rr, prev_rr = 1'b0;

    always @(negedge clk) begin
        if (cyc >= 3) begin
            act_fp = pmem_read_fp | pmem_write_fp;
            if (act_fp && !prev_fp) begin
                if (q_srv_fp.size() == 0) chk("fp_srv_unexpected", 128'(1), 128'(0));
                else begin
                    s_fp = q_srv_fp.pop_front();
                    chk("fp_srv_cycle", 128'(cyc), 128'(s_fp.cyc));
                    chk("fp_srv_grant", 128'(grant_id_fp), 128'(s_fp.gid));
                    chk("fp_srv_read", 128'(pmem_read_fp), 128'(s_fp.rd));
                    chk("fp_srv_write", 128'(pmem_write_fp), 128'(s_fp.wr));
                    chk("fp_srv_addr", 128'(pmem_address_fp), 128'(s_fp.addr));
                    chk("fp_srv_wdata", pmem_wdata_fp, s_fp.wdata);
                end
            end
            prev_fp = act_fp;
            if (req_resp_fp != 2'b00) begin
                if (q_rsp_fp.size() == 0) chk("fp_resp_unexpected", 128'(req_resp_fp), 128'(0));
                else begin
                    r_fp = q_rsp_fp.pop_front();
                    chk("fp_resp_cycle", 128'(cyc), 128'(r_fp.cyc));
                    chk("fp_resp_vec", 128'({1'b0, req_resp_fp}), 128'(r_fp.resp));
                    chk("fp_resp_rdata", req_rdata_fp, r_fp.rdata);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cyc >= 3) begin
            act_rr = pmem_read_rr | pmem_write_rr;
            if (act_rr && !prev_rr) begin
                if (q_srv_rr.size() == 0) chk("rr_srv_unexpected", 128'(1), 128'(0));
                else begin
                    s_rr = q_srv_rr.pop_front();
                    chk("rr_srv_cycle", 128'(cyc), 128'(s_rr.cyc));
                    chk("rr_srv_grant", 128'(grant_id_rr), 128'(s_rr.gid));
                    chk("rr_srv_read", 128'(pmem_read_rr), 128'(s_rr.rd));
                    chk("rr_srv_write", 128'(pmem_write_rr), 128'(s_rr.wr));
                    chk("rr_srv_addr", 128'(pmem_address_rr), 128'(s_rr.addr));
                    chk("rr_srv_wdata", pmem_wdata_rr, s_rr.wdata);
                end
            end
            prev_rr = act_rr;
            if (req_resp_rr != 3'b000) begin
                if (q_rsp_rr.size() == 0) chk("rr_resp_unexpected", 128'(req_resp_rr), 128'(0));
                else begin
                    r_rr = q_rsp_rr.pop_front();
                    chk("rr_resp_cycle", 128'(cyc), 128'(r_rr.cyc));
                    chk("rr_resp_vec", 128'(req_resp_rr), 128'(r_rr.resp));
                    chk("rr_resp_rdata", req_rdata_rr, r_rr.rdata);
                end
            end
        end
    end

    task automatic run_fp();
        logic [127:0] wd0 = 128'h0000_0000_0000_0000_0000_0000_AAAA_0000;
        logic [127:0] wd1 = 128'h0000_0000_0000_0000_0000_0000_BBBB_0001;
        logic [127:0] wdw = 128'hFEED_FACE_0123_4567_89AB_CDEF_1357_9BDF;
        // both read, port 0 wins, port 1 follows after RELEASE/IDLE
        wait_cyc(5);
        req_address_fp = {16'h0B10, 16'h0A00};
        req_wdata_fp   = {wd1, wd0};
        req_read_fp    = 2'b11;
        q_srv_fp.push_back('{6, 0, 1'b1, 1'b0, 16'h0A00, wd0});
        q_srv_fp.push_back('{11, 1, 1'b1, 1'b0, 16'h0B10, wd1});
        wait_cyc(8);
        pmem_resp_fp  = 1'b1;
        pmem_rdata_fp = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        q_rsp_fp.push_back('{8, 3'b001, 128'h1111_2222_3333_4444_5555_6666_7777_8888});
        wait_cyc(9);
        pmem_resp_fp   = 1'b0;
        req_read_fp[0] = 1'b0;
        wait_cyc(13);
        pmem_resp_fp  = 1'b1;
        pmem_rdata_fp = 128'h2;
        q_rsp_fp.push_back('{13, 3'b010, 128'h2});
        wait_cyc(14);
        pmem_resp_fp = 1'b0;
        req_read_fp  = 2'b00;
        // read+write on port 1: write wins
        wait_cyc(16);
        req_address_fp = {16'h1230, 16'h0A00};
        req_wdata_fp   = {wdw, wd0};
        req_read_fp    = 2'b10;
        req_write_fp   = 2'b10;
        q_srv_fp.push_back('{17, 1, 1'b0, 1'b1, 16'h1230, wdw});
        wait_cyc(18);
        pmem_resp_fp  = 1'b1;
        pmem_rdata_fp = 128'h3;
        q_rsp_fp.push_back('{18, 3'b010, 128'h3});
        wait_cyc(19);
        pmem_resp_fp = 1'b0;
        req_read_fp  = 2'b00;
        req_write_fp = 2'b00;
        // stray pmem_resp while idle
        wait_cyc(21);
        pmem_resp_fp = 1'b1;
        @(negedge clk);
        chk("idle_resp_req_resp", 128'(req_resp_fp), 128'(0));
        chk("idle_resp_busy", 128'(busy_fp), 128'(0));
        wait_cyc(22);
        pmem_resp_fp = 1'b0;
        @(negedge clk);
        chk("idle_resp_stays_idle", 128'(busy_fp), 128'(0));
        // abort: port 0 drops before completion, port 1 then granted
        wait_cyc(23);
        req_address_fp = {16'h0B10, 16'h0A00};
        req_wdata_fp   = {wd1, wd0};
        req_read_fp    = 2'b11;
        q_srv_fp.push_back('{24, 0, 1'b1, 1'b0, 16'h0A00, wd0});
        q_srv_fp.push_back('{27, 1, 1'b1, 1'b0, 16'h0B10, wd1});
        wait_cyc(25);
        req_read_fp[0] = 1'b0;
        wait_cyc(26);
        @(negedge clk);
        chk("abort_idle_busy", 128'(busy_fp), 128'(0));
        wait_cyc(28);
        pmem_resp_fp  = 1'b1;
        pmem_rdata_fp = 128'h4;
        q_rsp_fp.push_back('{28, 3'b010, 128'h4});
        wait_cyc(29);
        pmem_resp_fp = 1'b0;
        req_read_fp  = 2'b00;
        // reset during SERVE of port 1
        wait_cyc(31);
        req_read_fp = 2'b10;
        q_srv_fp.push_back('{32, 1, 1'b1, 1'b0, 16'h0B10, wd1});
        wait_cyc(32);
        rst_fp = 1'b1;
        wait_cyc(33);
        @(negedge clk);
        chk("rst_serve_busy", 128'(busy_fp), 128'(0));
        chk("rst_serve_pmem_read", 128'(pmem_read_fp), 128'(0));
        chk("rst_serve_grant_id", 128'(grant_id_fp), 128'(0));
        chk("rst_serve_req_resp", 128'(req_resp_fp), 128'(0));
        wait_cyc(34);
        rst_fp      = 1'b0;
        req_read_fp = 2'b00;
    endtask

    task automatic run_rr();
        logic [15:0]  a[3]    = '{16'h2000, 16'h2101, 16'h2202};
        int           gord[6] = '{0, 1, 2, 0, 1, 2};
        logic [127:0] wd[3];
        logic [127:0] rd;
        for (int i = 0; i < 3; i++) begin
            wd[i] = {4{32'h5000_0000 + 32'(i)}};
            req_address_rr[i*16 +: 16] = a[i];
            req_wdata_rr[i*128 +: 128] = wd[i];
        end
        wait_cyc(5);
        req_read_rr = 3'b111;
        for (int k = 0; k < 6; k++) begin
            q_srv_rr.push_back('{6 + 4*k, gord[k], 1'b1, 1'b0, a[gord[k]], wd[gord[k]]});
        end
        for (int k = 0; k < 6; k++) begin
            wait_cyc(7 + 4*k);
            rd            = {96'h0, 32'hA000_0000 + 32'(k)};
            pmem_resp_rr  = 1'b1;
            pmem_rdata_rr = rd;
            q_rsp_rr.push_back('{7 + 4*k, 3'(1 << gord[k]), rd});
            wait_cyc(8 + 4*k);
            pmem_resp_rr = 1'b0;
        end
        req_read_rr = 3'b000;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        rst_fp = 1'b1;          rst_rr = 1'b1;
        req_read_fp = '0;       req_write_fp = '0;
        req_address_fp = '0;    req_wdata_fp = '0;
        pmem_resp_fp = 1'b0;    pmem_rdata_fp = 128'hDEAD_BEEF_0000_0000_0000_0000_CAFE_F00D;
        req_read_rr = '0;       req_write_rr = '0;
        req_address_rr = '0;    req_wdata_rr = '0;
        pmem_resp_rr = 1'b0;    pmem_rdata_rr = 128'h0123_4567;
        wait_cyc(2);
        @(negedge clk);
        chk("reset_busy", 128'(busy_fp), 128'(0));
        chk("reset_grant_id", 128'(grant_id_fp), 128'(0));
        chk("reset_req_resp", 128'(req_resp_fp), 128'(0));
        chk("reset_pmem_read", 128'(pmem_read_fp), 128'(0));
        chk("reset_pmem_write", 128'(pmem_write_fp), 128'(0));
        chk("reset_pmem_address", 128'(pmem_address_fp), 128'(0));
        chk("reset_req_rdata", req_rdata_fp, 128'hDEAD_BEEF_0000_0000_0000_0000_CAFE_F00D);
        chk("reset_rr_busy", 128'(busy_rr), 128'(0));
        chk("reset_rr_grant_id", 128'(grant_id_rr), 128'(0));
        wait_cyc(3);
        rst_fp = 1'b0;
        rst_rr = 1'b0;
        fork
            run_fp();
            run_rr();
        join
        wait_cyc(40);
        @(negedge clk);
        chk("fp_srv_drained", 128'(q_srv_fp.size()), 128'(0));
        chk("fp_rsp_drained", 128'(q_rsp_fp.size()), 128'(0));
        chk("rr_srv_drained", 128'(q_srv_rr.size()), 128'(0));
        chk("rr_rsp_drained", 128'(q_rsp_rr.size()), 128'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
